cordic_polar_pipe: RTL

CORDIC_POLAR_PIPE -- requirements
Module: cordic_polar_pipe

---
 rtl/cordic_pkg.sv | 25 ++
 rtl/cordic_stage.sv | 50 +++++
 rtl/cordic_polar_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants: arctangent table, rounding helper, gain inverse
package cordic_pkg;

  localparam int KINV_Q16 = 39797;

  // atan(2^-i) as a binary angle where the full circle is 2^32
  localparam logic [31:0] ATAN_TABLE [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  // Round-to-nearest reduction of the 32-bit table entry to an aw-bit circle
  function automatic logic [31:0] atan_round(input int i, input int aw);
    logic [32:0] sum;
    sum = {1'b0, ATAN_TABLE[i[4:0]]} + (33'd1 << (31 - aw));
    return 32'(sum >> (32 - aw));
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one registered vectoring micro-rotation driving y toward zero
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int XW    = 18,
  parameter int ZW    = 17,
  parameter int STAGE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 prev_valid,
  input  logic signed [XW-1:0] prev_x,
  input  logic signed [XW-1:0] prev_y,
  input  logic signed [ZW-1:0] prev_z,
  output logic                 next_valid,
  output logic signed [XW-1:0] next_x,
  output logic signed [XW-1:0] next_y,
  output logic signed [ZW-1:0] next_z
);

  localparam logic signed [ZW-1:0] ATAN_Z = ZW'(atan_round(STAGE, ZW - 1));

  logic signed [XW-1:0] x_shr;
  logic signed [XW-1:0] y_shr;

  assign x_shr = prev_x >>> STAGE;
  assign y_shr = prev_y >>> STAGE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_valid <= 1'b0;
      next_x     <= '0;
      next_y     <= '0;
      next_z     <= '0;
    end else if (ena) begin
      next_valid <= prev_valid;
      if (!prev_y[XW-1]) begin
        next_x <= prev_x + y_shr;
        next_y <= prev_y - x_shr;
        next_z <= prev_z + ATAN_Z;
      end else begin
        next_x <= prev_x - y_shr;
        next_y <= prev_y + x_shr;
        next_z <= prev_z - ATAN_Z;
      end
    end
  end

endmodule

// File: rtl/cordic_polar_pipe.sv
// rtl/cordic_polar_pipe.sv - pipelined rectangular-to-polar converter (fold, CORDIC stages, post scale)
module cordic_polar_pipe
  import cordic_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int ITER      = 15,
  parameter int GAIN_COMP = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  output logic                 out_valid,
  output logic [DW+1:0]        r_out,
  output logic [AW-1:0]        a_out
);

  localparam int XW = DW + 2;
  localparam int ZW = AW + 1;
  localparam logic [AW-1:0] OFF_Q1 = AW'(1) << (AW - 2);
  localparam logic [AW-1:0] OFF_Q3 = AW'(3) << (AW - 2);

  logic signed [XW-1:0] x_ext;
  logic signed [XW-1:0] y_ext;
  logic signed [XW-1:0] fold_x;
  logic signed [XW-1:0] fold_y;
  logic [AW-1:0]        fold_off;
  logic                 fold_zero;

  assign x_ext = {{2{x_in[DW-1]}}, x_in};
  assign y_ext = {{2{y_in[DW-1]}}, y_in};

  // Rotate the left half-plane into the right so the stages only see |angle| <= 90 deg
  always_comb begin
    fold_x    = x_ext;
    fold_y    = y_ext;
    fold_off  = '0;
    fold_zero = (x_in == '0) && (y_in == '0);
    if (x_in[DW-1]) begin
      if (!y_in[DW-1]) begin
        fold_x   = y_ext;
        fold_y   = -x_ext;
        fold_off = OFF_Q1;
      end else begin
        fold_x   = -y_ext;
        fold_y   = x_ext;
        fold_off = OFF_Q3;
      end
    end
  end

  logic                 pre_valid;
  logic signed [XW-1:0] pre_x;
  logic signed [XW-1:0] pre_y;
  logic [AW-1:0]        off_q  [ITER+1];
  logic                 zero_q [ITER+1];

  // Quadrant offset and zero flag ride alongside the data, one slot per stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_valid <= 1'b0;
      pre_x     <= '0;
      pre_y     <= '0;
      for (int i = 0; i <= ITER; i++) begin
        off_q[i]  <= '0;
        zero_q[i] <= 1'b0;
      end
    end else if (ena) begin
      pre_valid <= in_valid;
      pre_x     <= fold_x;
      pre_y     <= fold_y;
      off_q[0]  <= fold_off;
      zero_q[0] <= fold_zero;
      for (int i = 1; i <= ITER; i++) begin
        off_q[i]  <= off_q[i-1];
        zero_q[i] <= zero_q[i-1];
      end
    end
  end

  logic                 sv [ITER+1];
  logic signed [XW-1:0] sx [ITER+1];
  logic signed [XW-1:0] sy [ITER+1];
  logic signed [ZW-1:0] sz [ITER+1];

  assign sv[0] = pre_valid;
  assign sx[0] = pre_x;
  assign sy[0] = pre_y;
  assign sz[0] = '0;

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    cordic_stage #(
      .XW    (XW),
      .ZW    (ZW),
      .STAGE (i)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .prev_valid (sv[i]),
      .prev_x     (sx[i]),
      .prev_y     (sy[i]),
      .prev_z     (sz[i]),
      .next_valid (sv[i+1]),
      .next_x     (sx[i+1]),
      .next_y     (sy[i+1]),
      .next_z     (sz[i+1])
    );
  end

  logic [XW-1:0]    x_mag;
  logic [XW+15:0]   x_scaled;
  logic [XW-1:0]    r_next;
  logic [AW-1:0]    a_next;

  // x never goes negative once folded, so it can be reinterpreted as unsigned
  assign x_mag    = sx[ITER];
  assign x_scaled = {16'b0, x_mag} * (XW + 16)'(KINV_Q16);
  assign r_next   = (GAIN_COMP != 0) ? XW'(x_scaled >> 16) : x_mag;
  assign a_next   = off_q[ITER] + AW'(sz[ITER]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      r_out     <= '0;
      a_out     <= '0;
    end else if (ena) begin
      out_valid <= sv[ITER];
      r_out     <= zero_q[ITER] ? '0 : r_next;
      a_out     <= zero_q[ITER] ? '0 : a_next;
    end
  end

endmodule
